// File: rtl/io_cmd_pkg.sv
// Shared types for the multichannel IO command controller: opcodes, status-word
// layout and the per-channel queue entry.
package io_cmd_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_STORE  = 2'b01,
        OP_ATOMIC = 2'b10,
        OP_STATUS = 2'b11
    } io_opcode_e;

    localparam int STATUS_OCC_LSB   = 0;
    localparam int STATUS_OUT_LSB   = 4;
    localparam int STATUS_VALID_BIT = 8;

    // Queue entries carry data at the controller's default data width.
    localparam int IO_DATA_W = 16;

    typedef struct packed {
        logic                 respreq;
        logic [3:0]           destreg;
        logic [IO_DATA_W-1:0] data;
    } io_queue_entry_t;

    function automatic logic [IO_DATA_W-1:0] make_status(
        input logic [3:0] occ,
        input logic [3:0] outstanding,
        input logic       valid
    );
        logic [IO_DATA_W-1:0] word;
        word                           = '0;
        word[STATUS_OCC_LSB +: 4]      = occ;
        word[STATUS_OUT_LSB +: 4]      = outstanding;
        word[STATUS_VALID_BIT]         = valid;
        return word;
    endfunction

endpackage

// File: rtl/io_channel_queue.sv
// Per-channel command FIFO. The head is only visible once an entry has been
// registered, so there is no bypass path from an empty queue.
module io_channel_queue
    import io_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  io_queue_entry_t push_entry,
    input  logic            pop,
    output io_queue_entry_t head,
    output logic            empty,
    output logic            full,
    output logic [3:0]      occupancy
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
    localparam logic [3:0]     DEPTH_V = 4'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;
    io_queue_entry_t  mem_q [DEPTH];
    io_queue_entry_t  mem_d [DEPTH];
    logic             push_ok, pop_ok;

    assign empty     = (count_q == 4'd0);
    assign full      = (count_q == DEPTH_V);
    assign occupancy = count_q;
    assign head      = mem_q[rd_ptr_q];

    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 4'd1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/io_multichannel_command_controller.sv
// Decodes IO commands into per-channel queues, tracks atomic loads in flight and
// arbitrates channel responses round-robin onto the single writeback port.
module io_multichannel_command_controller
    import io_cmd_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int DATABITWIDTH   = 16,
    parameter int QUEUEDEPTH     = 4,
    parameter int MAXOUTSTANDING = 3,
    parameter int CHSELLSB       = 12
) (
    input  logic                                    sys_clk,
    input  logic                                    sync_rst,
    input  logic                                    clk_en,
    input  logic                                    CommandACK,
    output logic                                    CommandREQ,
    input  logic [3:0]                              MinorOpcodeIn,
    input  logic [DATABITWIDTH-1:0]                 CommandAddressIn,
    input  logic [DATABITWIDTH-1:0]                 CommandDataIn,
    input  logic [3:0]                              CommandDestReg,
    output logic                                    WritebackACK,
    input  logic                                    WritebackREQ,
    output logic [3:0]                              WritebackDestReg,
    output logic [DATABITWIDTH-1:0]                 WritebackDataOut,
    output logic [CHANNELS-1:0]                     IOOut_ACK,
    input  logic [CHANNELS-1:0]                     IOOut_REQ,
    output logic [CHANNELS-1:0]                     IOOut_ResponseRequested,
    output logic [CHANNELS-1:0][3:0]                IOOut_DestReg,
    output logic [CHANNELS-1:0][DATABITWIDTH-1:0]   IOOut_Data,
    input  logic [CHANNELS-1:0]                     IOIn_ACK,
    output logic [CHANNELS-1:0]                     IOIn_REQ,
    input  logic [CHANNELS-1:0]                     IOIn_RegResponseFlag,
    input  logic [CHANNELS-1:0][3:0]                IOIn_DestReg,
    input  logic [CHANNELS-1:0][DATABITWIDTH-1:0]   IOIn_Data
);

    localparam int CH_W = $clog2(CHANNELS);

    logic                               active;
    logic [CH_W-1:0]                    cmd_ch;
    io_opcode_e                         cmd_op;
    logic                               cmd_req, cmd_xfer, queue_room, load_ok;
    io_queue_entry_t                    push_entry;
    io_queue_entry_t                    q_head [CHANNELS];
    logic [CHANNELS-1:0]                q_empty, q_full, q_push, q_pop;
    logic [CHANNELS-1:0][3:0]           q_occ;
    logic [CHANNELS-1:0]                atomic_inc, resp_dec;
    logic [CH_W-1:0]                    rr_q, rr_d, grant_ch;
    logic                               grant_valid, grant_reg, reg_xfer, mem_accept;
    logic [CHANNELS-1:0][3:0]           outstanding_q, outstanding_d;
    logic [CHANNELS-1:0][DATABITWIDTH-1:0] load_buf_q, load_buf_d;
    logic [CHANNELS-1:0]                load_valid_q, load_valid_d;
    logic                               unused_inputs;

    assign active        = clk_en && !sync_rst;
    assign cmd_ch        = CommandAddressIn[CHSELLSB +: CH_W];
    assign cmd_op        = io_opcode_e'(MinorOpcodeIn[3:2]);
    assign unused_inputs = ^{CommandAddressIn, MinorOpcodeIn[1:0]};

    always_comb begin
        logic [CH_W-1:0] cand;
        cand        = '0;
        grant_valid = 1'b0;
        grant_ch    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = rr_q + CH_W'(k);
            if (!grant_valid && IOIn_ACK[cand]) begin
                grant_valid = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    assign grant_reg  = grant_valid && IOIn_RegResponseFlag[grant_ch];
    assign reg_xfer   = active && grant_reg && WritebackREQ;
    assign mem_accept = active && grant_valid && !IOIn_RegResponseFlag[grant_ch];

    always_comb begin
        IOIn_REQ = '0;
        if (active && grant_valid) begin
            IOIn_REQ[grant_ch] = grant_reg ? WritebackREQ : 1'b1;
        end
    end

    // A queue with a departing head has room even when full.
    always_comb begin
        queue_room = !q_full[cmd_ch] || q_pop[cmd_ch];
        load_ok    = WritebackREQ && !grant_reg;
        case (cmd_op)
            OP_STORE:  cmd_req = queue_room;
            OP_ATOMIC: cmd_req = queue_room && (outstanding_q[cmd_ch] < 4'(MAXOUTSTANDING));
            default:   cmd_req = load_ok;
        endcase
        cmd_req  = cmd_req && active;
        cmd_xfer = cmd_req && CommandACK;
    end

    assign CommandREQ = cmd_req;

    always_comb begin
        WritebackACK     = 1'b0;
        WritebackDestReg = '0;
        WritebackDataOut = '0;
        if (active) begin
            if (grant_reg) begin
                WritebackACK     = 1'b1;
                WritebackDestReg = IOIn_DestReg[grant_ch];
                WritebackDataOut = IOIn_Data[grant_ch];
            end else if (cmd_op == OP_LOAD || cmd_op == OP_STATUS) begin
                WritebackACK     = CommandACK;
                WritebackDestReg = CommandDestReg;
                WritebackDataOut = (cmd_op == OP_LOAD) ? load_buf_q[cmd_ch]
                                 : DATABITWIDTH'(make_status(q_occ[cmd_ch],
                                                             outstanding_q[cmd_ch],
                                                             load_valid_q[cmd_ch]));
            end
        end
    end

    assign push_entry = '{respreq: (cmd_op == OP_ATOMIC),
                          destreg: CommandDestReg,
                          data:    IO_DATA_W'(CommandDataIn)};

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic show;
        assign show          = !sync_rst && !q_empty[i];
        assign IOOut_ACK[i]  = active && !q_empty[i];
        assign q_pop[i]      = IOOut_ACK[i] && IOOut_REQ[i];
        assign q_push[i]     = cmd_xfer && (cmd_ch == CH_W'(i))
                             && (cmd_op == OP_STORE || cmd_op == OP_ATOMIC);
        assign atomic_inc[i] = cmd_xfer && (cmd_op == OP_ATOMIC) && (cmd_ch == CH_W'(i));
        assign resp_dec[i]   = reg_xfer && (grant_ch == CH_W'(i));
        assign IOOut_ResponseRequested[i] = show && q_head[i].respreq;
        assign IOOut_DestReg[i]           = show ? q_head[i].destreg : 4'd0;
        assign IOOut_Data[i]              = show ? DATABITWIDTH'(q_head[i].data) : '0;

        io_channel_queue #(
            .DEPTH (QUEUEDEPTH)
        ) u_queue (
            .clk        (sys_clk),
            .rst        (sync_rst),
            .push       (q_push[i]),
            .push_entry (push_entry),
            .pop        (q_pop[i]),
            .head       (q_head[i]),
            .empty      (q_empty[i]),
            .full       (q_full[i]),
            .occupancy  (q_occ[i])
        );
    end

    // A load clears loadvalid before a same-cycle memory response sets it again.
    always_comb begin
        rr_d          = rr_q;
        load_buf_d    = load_buf_q;
        load_valid_d  = load_valid_q;
        outstanding_d = outstanding_q;
        if (reg_xfer || mem_accept) begin
            rr_d = grant_ch + CH_W'(1);
        end
        if (cmd_xfer && cmd_op == OP_LOAD) begin
            load_valid_d[cmd_ch] = 1'b0;
        end
        if (mem_accept) begin
            load_buf_d[grant_ch]   = IOIn_Data[grant_ch];
            load_valid_d[grant_ch] = 1'b1;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (atomic_inc[i] && !resp_dec[i]) begin
                outstanding_d[i] = outstanding_q[i] + 4'd1;
            end else if (resp_dec[i] && !atomic_inc[i] && outstanding_q[i] != 4'd0) begin
                outstanding_d[i] = outstanding_q[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sync_rst) begin
            rr_q          <= '0;
            load_buf_q    <= '0;
            load_valid_q  <= '0;
            outstanding_q <= '0;
        end else if (clk_en) begin
            rr_q          <= rr_d;
            load_buf_q    <= load_buf_d;
            load_valid_q  <= load_valid_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_io_multichannel_command_controller.sv
// Directed bench for the multichannel IO command controller: inputs change just
// after each rising edge and outputs are sampled on the falling edge.
module tb_io_multichannel_command_controller;

    localparam int CH = 4;
    localparam int DW = 16;

    logic                 sys_clk = 1'b0;
    logic                 sync_rst, clk_en;
    logic                 CommandACK, CommandREQ;
    logic [3:0]           MinorOpcodeIn;
    logic [DW-1:0]        CommandAddressIn, CommandDataIn;
    logic [3:0]           CommandDestReg;
    logic                 WritebackACK, WritebackREQ;
    logic [3:0]           WritebackDestReg;
    logic [DW-1:0]        WritebackDataOut;
    logic [CH-1:0]        IOOut_ACK, IOOut_REQ, IOOut_ResponseRequested;
    logic [CH-1:0][3:0]   IOOut_DestReg;
    logic [CH-1:0][DW-1:0] IOOut_Data;
    logic [CH-1:0]        IOIn_ACK, IOIn_REQ, IOIn_RegResponseFlag;
    logic [CH-1:0][3:0]   IOIn_DestReg;
    logic [CH-1:0][DW-1:0] IOIn_Data;

    int checkCount = 0;
    int failCount  = 0;

    io_multichannel_command_controller #(
        .CHANNELS       (CH),
        .DATABITWIDTH   (DW),
        .QUEUEDEPTH     (4),
        .MAXOUTSTANDING (3),
        .CHSELLSB       (12)
    ) dut (
        .sys_clk                 (sys_clk),
        .sync_rst                (sync_rst),
        .clk_en                  (clk_en),
        .CommandACK              (CommandACK),
        .CommandREQ              (CommandREQ),
        .MinorOpcodeIn           (MinorOpcodeIn),
        .CommandAddressIn        (CommandAddressIn),
        .CommandDataIn           (CommandDataIn),
        .CommandDestReg          (CommandDestReg),
        .WritebackACK            (WritebackACK),
        .WritebackREQ            (WritebackREQ),
        .WritebackDestReg        (WritebackDestReg),
        .WritebackDataOut        (WritebackDataOut),
        .IOOut_ACK               (IOOut_ACK),
        .IOOut_REQ               (IOOut_REQ),
        .IOOut_ResponseRequested (IOOut_ResponseRequested),
        .IOOut_DestReg           (IOOut_DestReg),
        .IOOut_Data              (IOOut_Data),
        .IOIn_ACK                (IOIn_ACK),
        .IOIn_REQ                (IOIn_REQ),
        .IOIn_RegResponseFlag    (IOIn_RegResponseFlag),
        .IOIn_DestReg            (IOIn_DestReg),
        .IOIn_Data               (IOIn_Data)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idleInputs();
        sync_rst             = 1'b0;
        clk_en               = 1'b1;
        CommandACK           = 1'b0;
        MinorOpcodeIn        = 4'h0;
        CommandAddressIn     = '0;
        CommandDataIn        = '0;
        CommandDestReg       = 4'h0;
        WritebackREQ         = 1'b0;
        IOOut_REQ            = '0;
        IOIn_ACK             = '0;
        IOIn_RegResponseFlag = '0;
        IOIn_DestReg         = '0;
        IOIn_Data            = '0;
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] addr,
                                 input logic [15:0] data, input logic [3:0] dest);
        MinorOpcodeIn    = {op, 2'b00};
        CommandAddressIn = addr;
        CommandDataIn    = data;
        CommandDestReg   = dest;
        CommandACK       = 1'b1;
    endtask

    task automatic statusRead(input logic [15:0] addr, input logic [15:0] expected,
                              input string tag);
        applyStimulus(2'b11, addr, 16'h0, 4'hF);
        WritebackREQ = 1'b1;
        @(negedge sys_clk);
        checkOutput(tag, WritebackDataOut, expected);
        nextCycle();
        CommandACK   = 1'b0;
        WritebackREQ = 1'b0;
    endtask

    initial begin
        int rrGrant[4];
        logic [15:0] drainData[4];
        logic [15:0] addr;
        rrGrant   = '{0, 1, 3, 0};
        drainData = '{16'h1001, 16'h1002, 16'h1003, 16'h5555};

        // Reset with every handshake input asserted.
        idleInputs();
        sync_rst             = 1'b1;
        applyStimulus(2'b01, 16'h2000, 16'h1111, 4'h1);
        WritebackREQ         = 1'b1;
        IOIn_ACK             = 4'hF;
        IOIn_RegResponseFlag = 4'hF;
        IOOut_REQ            = 4'hF;
        @(negedge sys_clk);
        checkOutput("rst_cmdreq", CommandREQ, 1'b0);
        checkOutput("rst_wback", WritebackACK, 1'b0);
        checkOutput("rst_ioinreq", IOIn_REQ, 4'h0);
        checkOutput("rst_iooutack", IOOut_ACK, 4'h0);
        checkOutput("rst_wbdata", WritebackDataOut, 16'h0);
        nextCycle();
        idleInputs();
        nextCycle();

        // Round-robin over register responses on ch0, ch1, ch3 while a load waits.
        IOIn_ACK             = 4'b1011;
        IOIn_RegResponseFlag = 4'b1011;
        for (int c = 0; c < CH; c++) begin
            IOIn_DestReg[c] = 4'(8 + c);
            IOIn_Data[c]    = 16'hC000 + 16'(c);
        end
        WritebackREQ = 1'b1;
        applyStimulus(2'b00, 16'h0000, 16'h0, 4'h2);
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            checkOutput("rr_dest", WritebackDestReg, 32'(8 + rrGrant[i]));
            checkOutput("rr_data", WritebackDataOut, 32'h0000C000 + 32'(rrGrant[i]));
            checkOutput("rr_ioinreq", IOIn_REQ, 32'(1) << rrGrant[i]);
            checkOutput("rr_loadstall", CommandREQ, 1'b0);
            nextCycle();
        end
        idleInputs();
        statusRead(16'h0000, 16'h0000, "rr_sat_ch0");

        // Store to ch2 appears on the port one cycle later and pops on REQ.
        applyStimulus(2'b01, 16'h2000, 16'hBEEF, 4'h5);
        @(negedge sys_clk);
        checkOutput("st_cmdreq", CommandREQ, 1'b1);
        checkOutput("st_nobypass", IOOut_ACK, 4'h0);
        nextCycle();
        idleInputs();
        @(negedge sys_clk);
        checkOutput("st_ack", IOOut_ACK, 4'b0100);
        checkOutput("st_data", IOOut_Data[2], 16'hBEEF);
        checkOutput("st_resp", IOOut_ResponseRequested, 4'h0);
        checkOutput("st_dest", IOOut_DestReg[2], 4'h5);
        nextCycle();
        IOOut_REQ = 4'b0100;
        nextCycle();
        IOOut_REQ = 4'b0000;
        @(negedge sys_clk);
        checkOutput("st_pop", IOOut_ACK, 4'h0);
        nextCycle();

        // Atomic loads to ch1 hit the outstanding limit.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b10, 16'h1000, 16'h2000 + 16'(i), 4'h3);
            @(negedge sys_clk);
            checkOutput("at_accept", CommandREQ, 1'b1);
            nextCycle();
        end
        @(negedge sys_clk);
        checkOutput("at_limit", CommandREQ, 1'b0);
        checkOutput("at_respreq", IOOut_ResponseRequested[1], 1'b1);
        nextCycle();
        IOIn_ACK             = 4'b0010;
        IOIn_RegResponseFlag = 4'b0010;
        IOIn_DestReg[1]      = 4'h7;
        IOIn_Data[1]         = 16'hAAAA;
        WritebackREQ         = 1'b1;
        @(negedge sys_clk);
        checkOutput("at_block", CommandREQ, 1'b0);
        checkOutput("at_wback", WritebackACK, 1'b1);
        checkOutput("at_wbdata", WritebackDataOut, 16'hAAAA);
        checkOutput("at_wbdest", WritebackDestReg, 4'h7);
        checkOutput("at_ioinreq", IOIn_REQ, 4'b0010);
        nextCycle();
        idleInputs();
        statusRead(16'h1000, 16'h0023, "at_status_after_rsp");
        applyStimulus(2'b10, 16'h1000, 16'h2003, 4'h3);
        @(negedge sys_clk);
        checkOutput("at_reaccept", CommandREQ, 1'b1);
        nextCycle();
        idleInputs();
        statusRead(16'h1000, 16'h0034, "at_status_full");
        IOOut_REQ = 4'b0010;
        for (int i = 0; i < 4; i++) nextCycle();
        IOOut_REQ = 4'b0000;
        statusRead(16'h1000, 16'h0030, "at_drained");

        // Fill ch0 with the port stalled, then push and pop together at full.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b01, 16'h0000, 16'h1000 + 16'(i), 4'(i));
            @(negedge sys_clk);
            checkOutput("qf_push", CommandREQ, 1'b1);
            nextCycle();
        end
        applyStimulus(2'b01, 16'h0000, 16'h5555, 4'hE);
        @(negedge sys_clk);
        checkOutput("qf_full", CommandREQ, 1'b0);
        nextCycle();
        IOOut_REQ = 4'b0001;
        @(negedge sys_clk);
        checkOutput("qf_pushpop", CommandREQ, 1'b1);
        checkOutput("qf_head", IOOut_Data[0], 16'h1000);
        nextCycle();
        idleInputs();
        statusRead(16'h0000, 16'h0004, "qf_occ");
        IOOut_REQ = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            checkOutput("qf_order", IOOut_Data[0], drainData[i]);
            nextCycle();
        end
        IOOut_REQ = 4'b0000;
        @(negedge sys_clk);
        checkOutput("qf_empty", IOOut_ACK, 4'h0);
        nextCycle();

        // Memory response fills the ch3 load buffer; loads consume it.
        IOIn_ACK     = 4'b1000;
        IOIn_Data[3] = 16'h1234;
        @(negedge sys_clk);
        checkOutput("mr_ioinreq", IOIn_REQ, 4'b1000);
        checkOutput("mr_nowback", WritebackACK, 1'b0);
        nextCycle();
        idleInputs();
        statusRead(16'h3000, 16'h0100, "mr_valid_set");
        applyStimulus(2'b00, 16'h3000, 16'h0, 4'h9);
        WritebackREQ = 1'b1;
        @(negedge sys_clk);
        checkOutput("ld_data", WritebackDataOut, 16'h1234);
        checkOutput("ld_dest", WritebackDestReg, 4'h9);
        checkOutput("ld_wback", WritebackACK, 1'b1);
        checkOutput("ld_cmdreq", CommandREQ, 1'b1);
        nextCycle();
        idleInputs();
        statusRead(16'h3000, 16'h0000, "mr_valid_clr");
        IOIn_ACK     = 4'b1000;
        IOIn_Data[3] = 16'h5678;
        applyStimulus(2'b00, 16'h3000, 16'h0, 4'h9);
        WritebackREQ = 1'b1;
        @(negedge sys_clk);
        checkOutput("sc_olddata", WritebackDataOut, 16'h1234);
        nextCycle();
        idleInputs();
        statusRead(16'h3000, 16'h0100, "sc_valid_kept");
        applyStimulus(2'b00, 16'h3000, 16'h0, 4'h9);
        WritebackREQ = 1'b1;
        @(negedge sys_clk);
        checkOutput("sc_newdata", WritebackDataOut, 16'h5678);
        nextCycle();
        idleInputs();

        // Partially fill queues, check the stall, then reset mid-burst.
        applyStimulus(2'b01, 16'h0000, 16'hD000, 4'h1); nextCycle();
        applyStimulus(2'b01, 16'h0000, 16'hD001, 4'h1); nextCycle();
        applyStimulus(2'b01, 16'h2000, 16'hD002, 4'h1); nextCycle();
        applyStimulus(2'b01, 16'h2000, 16'hD003, 4'h1); nextCycle();
        applyStimulus(2'b10, 16'h3000, 16'hD004, 4'h1); nextCycle();
        idleInputs();
        clk_en = 1'b0;
        applyStimulus(2'b01, 16'h0000, 16'hEEEE, 4'h2);
        @(negedge sys_clk);
        checkOutput("ce_cmdreq", CommandREQ, 1'b0);
        checkOutput("ce_iooutack", IOOut_ACK, 4'h0);
        nextCycle();
        idleInputs();
        @(negedge sys_clk);
        checkOutput("ce_resume", IOOut_ACK, 4'b1101);
        nextCycle();
        statusRead(16'h0000, 16'h0002, "ce_occ");
        sync_rst             = 1'b1;
        applyStimulus(2'b01, 16'h2000, 16'h7777, 4'h3);
        WritebackREQ         = 1'b1;
        IOIn_ACK             = 4'hF;
        IOIn_RegResponseFlag = 4'hF;
        @(negedge sys_clk);
        checkOutput("rb_iooutack", IOOut_ACK, 4'h0);
        checkOutput("rb_data0", IOOut_Data[0], 16'h0);
        checkOutput("rb_data2", IOOut_Data[2], 16'h0);
        checkOutput("rb_ioinreq", IOIn_REQ, 4'h0);
        checkOutput("rb_cmdreq", CommandREQ, 1'b0);
        checkOutput("rb_wbdata", WritebackDataOut, 16'h0);
        nextCycle();
        idleInputs();
        @(negedge sys_clk);
        checkOutput("rb_after_ack", IOOut_ACK, 4'h0);
        checkOutput("rb_after_resp", IOOut_ResponseRequested, 4'h0);
        nextCycle();
        for (int c = 0; c < CH; c++) begin
            addr = 16'(c) << 12;
            statusRead(addr, 16'h0000, "rb_status");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
